doctor_key_arbiter: RTL and testbench
=====================================

# doctor_key_arbiter

Converts make/break keyboard events into the four doctor move strobes and the magnet toggle. Sits between the keyboard decoder and the doctor motion block. The motion block moves only when exactly one direction is active, so this block arbitrates overlapping arrow keys with "last pressed wins". It presents a frame-stable one-hot direction to the motion block.

## Interface
Parameters:
- KEY_UP, 9'h175, extended code of the up arrow
- KEY_DOWN, 9'h172, extended code of the down arrow
- KEY_LEFT, 9'h16B, extended code of the left arrow
- KEY_RIGHT, 9'h174, extended code of the right arrow
- KEY_MAGNET, 9'h029, code of the magnet toggle key (space)

Ports:
- clk  input  1  system clock
- resetN  input  1  asynchronous, active-low reset
- startOfFrame  input  1  one-cycle pulse per frame (30 Hz)
- keyCode  input  9  code of the current key event; bit 8 = extended
- make  input  1  one-cycle pulse: keyCode pressed (repeats while held)
- brakee  input  1  one-cycle pulse: keyCode released
- game_en  input  1  level; 0 = game not running
- Up_Move  output  1  registered direction strobe
- Down_Move  output  1  registered direction strobe
- Right_Move  output  1  registered direction strobe
- Left_Move  output  1  registered direction strobe
- magnet_on  output  1  registered magnet state

## Operation
- **Direction encoding:** 0 = up, 1 = down, 2 = right, 3 = left.
- **Press-order stack:** 4 entries × 2 bits, plus count[2:0] (0..4) and held[3:0].
  - Entry count-1 is the top. Top = most recently pressed key still held.
- **make, direction key d, held[d] = 0:**
  - Write d at index count, count+1, set held[d].
  - Overflow is impossible: there are only 4 keys.
- **make, direction key d, held[d] = 1:** typematic repeat; no change.
- **brakee, direction key d, held[d] = 1:**
  - Remove d from its position; shift entries above it down one.
  - count-1, clear held[d].
- **brakee, key not held:** ignored. This covers a break after reset mid-press.
- **make and brakee both high:** event ignored.
- **Unknown keyCode:** ignored.
- **Pending direction:**
  - count = 0 → none.
  - Otherwise one-hot of top entry.
  - game_en = 0 → none.
- **Magnet:**
  - make of KEY_MAGNET with mag_held = 0: toggle magnet_on, set mag_held.
  - brakee of KEY_MAGNET: clear mag_held.
  - Repeats while held do not toggle.
  - game_en = 0 clears magnet_on and holds it at 0.
- **Key tracking while disabled:** the stack and held flags keep updating while game_en = 0. Keys held across enable therefore resume correctly.

## Timing
- **Reset:**
  - All outputs 0.
  - count = 0, held = 0, mag_held = 0, stack entries 0.
- **Stack update:** same clock edge as the make/brakee pulse; visible internally the next cycle.
- **Direction outputs:** registered and loaded only on edges where startOfFrame = 1; held constant for the rest of the frame.
  - On that edge the motion block samples the old value, so a key takes effect one frame after the startOfFrame that latched it.
  - A key event in the same cycle as startOfFrame is not included in that latch. It appears at the following startOfFrame.
- **magnet_on:** updates on the edge of the make pulse; 1-cycle latency, not frame-aligned.
  - game_en falling clears it on the next edge.
- **Output invariant:** at most one of the four move outputs is 1 in any cycle.
- **Reset mid-operation:** asynchronous clear of everything. Subsequent breaks for keys pressed before reset are ignored.

## Test plan
- **Reset:**
  - Assert resetN = 0 mid-frame with Left held → all outputs 0 immediately.
  - After release, a brakee of KEY_LEFT is ignored and count stays 0.
- **Single key:**
  - make KEY_UP; at the next startOfFrame edge Up_Move = 1.
  - brakee KEY_UP; at the following startOfFrame edge Up_Move = 0.
- **Overlap:**
  - make LEFT, make UP, then frame → Up_Move = 1 only.
  - brakee UP, then frame → Left_Move = 1.
  - brakee LEFT, then frame → all 0.
- **Middle removal and repeats:**
  - make RIGHT, DOWN, UP; brakee DOWN; frame → Up_Move = 1.
  - brakee UP, then frame → Right_Move = 1.
  - Repeated make UP pulses while UP is held do not change count.
- **Magnet:**
  - make SPACE ×5 (repeats) → magnet_on = 1 one cycle after the first make.
  - brakee, then make → magnet_on = 0.
  - game_en = 0 forces magnet_on = 0 and, at the next frame, all moves = 0.
- **Frame alignment:**
  - make RIGHT in the same cycle as startOfFrame → Right_Move still 0 after that edge.
  - Right_Move = 1 after the next startOfFrame.
  - Right_Move stays unchanged between frames.

Source files
------------

// File: rtl/doctor_key_arbiter.sv
// doctor_key_arbiter: turns keyboard make/break events into a frame-stable
// one-hot doctor move direction ("last pressed wins") plus a magnet toggle.
// Ports:
//   clk, resetN      - clock, asynchronous active-low reset
//   startOfFrame     - one-cycle frame pulse; direction outputs load here
//   keyCode[8:0]     - key event code, bit 8 = extended
//   make, brakee     - one-cycle press / release pulses for keyCode
//   game_en          - level, 0 = game not running
//   Up/Down/Right/Left_Move - registered one-hot direction strobes
//   magnet_on        - registered magnet state
module doctor_key_arbiter #(
    parameter logic [8:0] KEY_UP     = 9'h175,
    parameter logic [8:0] KEY_DOWN   = 9'h172,
    parameter logic [8:0] KEY_LEFT   = 9'h16B,
    parameter logic [8:0] KEY_RIGHT  = 9'h174,
    parameter logic [8:0] KEY_MAGNET = 9'h029
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       startOfFrame,
    input  logic [8:0] keyCode,
    input  logic       make,
    input  logic       brakee,
    input  logic       game_en,
    output logic       Up_Move,
    output logic       Down_Move,
    output logic       Right_Move,
    output logic       Left_Move,
    output logic       magnet_on
);

    // direction codes: 0 up, 1 down, 2 right, 3 left
    logic [1:0] r_stk [4];
    logic [2:0] r_cnt;
    logic [3:0] r_held;
    logic       r_mag_held;
    logic       r_mag;
    logic [3:0] r_moves;

    logic       w_is_dir;
    logic [1:0] w_dir;
    logic       w_mag_key;
    logic       w_mk;
    logic       w_bk;
    logic       w_push;
    logic       w_pop;
    logic [1:0] w_pos;
    logic [1:0] w_top;
    logic [3:0] w_pend;
    logic [1:0] w_stk_nxt [4];

    always_comb begin
        w_is_dir = 1'b1;
        w_dir    = 2'd0;
        unique case (keyCode)
            KEY_UP:    w_dir = 2'd0;
            KEY_DOWN:  w_dir = 2'd1;
            KEY_RIGHT: w_dir = 2'd2;
            KEY_LEFT:  w_dir = 2'd3;
            default:   w_is_dir = 1'b0;
        endcase
    end

    assign w_mag_key = (keyCode == KEY_MAGNET);
    // simultaneous make and break is treated as no event
    assign w_mk      = make & ~brakee;
    assign w_bk      = brakee & ~make;
    assign w_push    = w_mk & w_is_dir & ~r_held[w_dir];
    assign w_pop     = w_bk & w_is_dir & r_held[w_dir];

    // slot of the released key within the live part of the stack
    always_comb begin
        w_pos = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (3'(i) < r_cnt && r_stk[i] == w_dir)
                w_pos = 2'(i);
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++)
            w_stk_nxt[i] = r_stk[i];
        if (w_push) begin
            w_stk_nxt[r_cnt[1:0]] = w_dir;
        end else if (w_pop) begin
            // close the gap: entries above the removed one slide down
            for (int i = 0; i < 3; i++) begin
                if (2'(i) >= w_pos)
                    w_stk_nxt[i] = r_stk[i + 1];
            end
            w_stk_nxt[3] = 2'd0;
        end
    end

    assign w_top  = r_stk[r_cnt[1:0] - 2'd1];
    assign w_pend = (game_en && r_cnt != 3'd0) ? (4'b0001 << w_top) : 4'b0000;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < 4; i++)
                r_stk[i] <= 2'd0;
            r_cnt      <= 3'd0;
            r_held     <= 4'd0;
            r_mag_held <= 1'b0;
            r_mag      <= 1'b0;
            r_moves    <= 4'd0;
        end else begin
            for (int i = 0; i < 4; i++)
                r_stk[i] <= w_stk_nxt[i];
            if (w_push) begin
                r_cnt         <= r_cnt + 3'd1;
                r_held[w_dir] <= 1'b1;
            end else if (w_pop) begin
                r_cnt         <= r_cnt - 3'd1;
                r_held[w_dir] <= 1'b0;
            end
            // latch uses pre-edge stack, so same-cycle events wait a frame
            if (startOfFrame)
                r_moves <= w_pend;
            if (w_mk && w_mag_key)
                r_mag_held <= 1'b1;
            else if (w_bk && w_mag_key)
                r_mag_held <= 1'b0;
            if (!game_en)
                r_mag <= 1'b0;
            else if (w_mk && w_mag_key && !r_mag_held)
                r_mag <= ~r_mag;
        end
    end

    assign Up_Move    = r_moves[0];
    assign Down_Move  = r_moves[1];
    assign Right_Move = r_moves[2];
    assign Left_Move  = r_moves[3];
    assign magnet_on  = r_mag;

endmodule

// File: tb/tb_doctor_key_arbiter.sv
// tb_doctor_key_arbiter: scoreboard bench for doctor_key_arbiter with a
// press-order queue reference model, directed scenarios and random traffic.
module tb_doctor_key_arbiter;

    localparam logic [8:0] K_UP  = 9'h175;
    localparam logic [8:0] K_DN  = 9'h172;
    localparam logic [8:0] K_LF  = 9'h16B;
    localparam logic [8:0] K_RT  = 9'h174;
    localparam logic [8:0] K_MAG = 9'h029;

    logic       clk = 1'b0;
    logic       resetN;
    logic       sof;
    logic [8:0] kc;
    logic       mk;
    logic       bk;
    logic       en;
    logic       up_o, dn_o, rt_o, lf_o, mag_o;

    always #5 clk = ~clk;

    doctor_key_arbiter dut (
        .clk(clk),
        .resetN(resetN),
        .startOfFrame(sof),
        .keyCode(kc),
        .make(mk),
        .brakee(bk),
        .game_en(en),
        .Up_Move(up_o),
        .Down_Move(dn_o),
        .Right_Move(rt_o),
        .Left_Move(lf_o),
        .magnet_on(mag_o)
    );

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [3:0] mv;
        logic       mag;
    } exp_t;

    exp_t sb[$];

    // reference: list of held direction keys in press order (last = newest)
    int         mq[$];
    bit         m_mag;
    bit         m_magh;
    logic [3:0] m_mv;

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%b want=%b", name, $time, act, exp);
        end
    endtask

    function automatic int dir_of(input logic [8:0] k);
        if (k == K_UP) return 0;
        if (k == K_DN) return 1;
        if (k == K_RT) return 2;
        if (k == K_LF) return 3;
        return -1;
    endfunction

    function automatic logic [3:0] outs();
        return {lf_o, rt_o, dn_o, up_o};
    endfunction

    task automatic cyc(input bit s, input logic [8:0] k, input bit m,
                       input bit b, input bit e);
        int d;
        int idx;
        exp_t x;
        @(negedge clk);
        sof = s; kc = k; mk = m; bk = b; en = e;
        if (s)
            m_mv = (e && mq.size() > 0) ? (4'b0001 << mq[$]) : 4'b0000;
        if (!e)
            m_mag = 1'b0;
        else if (m && !b && k == K_MAG && !m_magh)
            m_mag = !m_mag;
        d = dir_of(k);
        if (m && !b) begin
            idx = -1;
            foreach (mq[i]) if (mq[i] == d) idx = i;
            if (d >= 0 && idx < 0) mq.push_back(d);
            if (k == K_MAG) m_magh = 1'b1;
        end else if (b && !m) begin
            idx = -1;
            foreach (mq[i]) if (mq[i] == d) idx = i;
            if (d >= 0 && idx >= 0) mq.delete(idx);
            if (k == K_MAG) m_magh = 1'b0;
        end
        x.mv = m_mv;
        x.mag = m_mag;
        sb.push_back(x);
    endtask

    task automatic mkk(input logic [8:0] k); cyc(0, k, 1, 0, 1); endtask
    task automatic brk(input logic [8:0] k); cyc(0, k, 0, 1, 1); endtask
    task automatic frame(); cyc(1, 9'h0, 0, 0, 1); endtask
    task automatic idle(); cyc(0, 9'h0, 0, 0, 1); endtask

    task automatic do_reset();
        @(negedge clk);
        sof = 0; mk = 0; bk = 0;
        #2 resetN = 1'b0;
        #1 chk("reset_moves", outs(), 4'b0000);
        chk("reset_mag", {3'b000, mag_o}, 4'b0000);
        mq.delete();
        m_mag = 0; m_magh = 0; m_mv = 4'b0000;
        @(negedge clk);
        resetN = 1'b1;
    endtask

    // monitor: compares every clocked response against the scoreboard
    always @(posedge clk) begin
        exp_t e;
        #1;
        chk("onehot", {3'b000, $countones(outs()) > 1}, 4'b0000);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("moves", outs(), e.mv);
            chk("magnet", {3'b000, mag_o}, {3'b000, e.mag});
        end
    end

    logic [8:0] keys [7];

    initial begin
        keys[0] = K_UP; keys[1] = K_DN; keys[2] = K_LF; keys[3] = K_RT;
        keys[4] = K_MAG; keys[5] = 9'h075; keys[6] = 9'h129;
        resetN = 1'b0;
        sof = 0; kc = 0; mk = 0; bk = 0; en = 1;
        m_mag = 0; m_magh = 0; m_mv = 0;
        repeat (2) @(negedge clk);
        chk("por_moves", outs(), 4'b0000);
        chk("por_mag", {3'b000, mag_o}, 4'b0000);
        resetN = 1'b1;

        // single key
        mkk(K_UP); frame(); idle(); brk(K_UP); frame(); idle();
        // overlap
        mkk(K_LF); mkk(K_UP); frame(); brk(K_UP); frame();
        brk(K_LF); frame();
        // middle removal and typematic repeats
        mkk(K_RT); mkk(K_DN); mkk(K_UP); brk(K_DN); frame();
        brk(K_UP); frame();
        mkk(K_UP); mkk(K_UP); mkk(K_UP); brk(K_UP); frame();
        brk(K_RT); frame();
        // both pulses and unknown codes are ignored
        cyc(0, K_UP, 1, 1, 1); frame();
        mkk(9'h075); frame();
        // magnet
        repeat (5) mkk(K_MAG);
        brk(K_MAG); mkk(K_MAG); brk(K_MAG); mkk(K_MAG);
        mkk(K_LF); frame();
        cyc(0, 9'h0, 0, 0, 0); cyc(1, 9'h0, 0, 0, 0);
        idle(); frame(); brk(K_LF); brk(K_MAG); frame();
        // frame alignment
        cyc(1, K_RT, 1, 0, 1); idle(); idle(); frame();
        idle(); idle(); idle(); brk(K_RT); idle(); frame();
        // reset mid-frame with left held; later break ignored
        mkk(K_LF); frame(); idle();
        do_reset();
        brk(K_LF); frame(); mkk(K_UP); frame(); brk(K_UP); frame();

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            int r;
            logic [8:0] k;
            k = keys[$urandom_range(6)];
            r = $urandom_range(9);
            if ($urandom_range(499) == 0)
                do_reset();
            cyc($urandom_range(5) == 0, k, r <= 3 || r == 7,
                (r >= 4 && r <= 7), $urandom_range(19) != 0);
        end

        idle();
        @(posedge clk);
        #2;
        chk("sb_drained", 4'(sb.size()), 4'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
